// File: rtl/multisim_pull_arbiter.sv
// Multi-channel pull arbiter: one shared pull request/response port serves
// NUM_CHANNELS valid/ready streams, with per-channel hit/miss backoff.

module multisim_pull_chan #(
  parameter int DATA_WIDTH     = 8,
  parameter int DELAY_ACTIVE   = 0,
  parameter int DELAY_INACTIVE = 3,
  parameter int DELAY_MAX      = 48,
  parameter int DLY_W          = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  rdy_i,
  input  logic                  busy_i,
  input  logic                  gnt_i,
  input  logic                  rsp_i,
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  elig_o
);
  typedef enum logic [1:0] {S_EMPTY, S_PENDING, S_FULL} st_e;

  localparam logic [DLY_W-1:0] DLY_ACT = DLY_W'(DELAY_ACTIVE);
  localparam logic [DLY_W-1:0] DLY_INA = DLY_W'(DELAY_INACTIVE);
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(DELAY_MAX);

  st_e                   st_q, st_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [DLY_W-1:0]      bo_q, bo_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;
  logic [DLY_W:0]        bo_dbl;

  // one extra bit so doubling near the cap cannot wrap before saturating
  assign bo_dbl = {bo_q, 1'b0};

  assign elig_o = en_i && !busy_i && (dly_q == '0) &&
                  ((st_q == S_EMPTY) || ((st_q == S_FULL) && rdy_i));
  assign vld_o  = vld_q;
  assign data_o = data_q;

  always_comb begin
    st_d   = st_q;
    dly_d  = (dly_q != '0) ? dly_q - 1'b1 : dly_q;
    bo_d   = bo_q;
    data_d = data_q;
    if (gnt_i)
      st_d = S_PENDING;
    else if ((st_q == S_FULL) && rdy_i)
      st_d = S_EMPTY;
    if (rsp_i && (st_q == S_PENDING)) begin
      if (hit_i) begin
        st_d   = S_FULL;
        data_d = rsp_data_i;
        dly_d  = DLY_ACT;
        bo_d   = DLY_INA;
      end else begin
        st_d  = S_EMPTY;
        dly_d = bo_q;
        bo_d  = (bo_dbl > {1'b0, DLY_MAX}) ? DLY_MAX : bo_dbl[DLY_W-1:0];
      end
    end
    vld_d = (st_d == S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_EMPTY;
      dly_q  <= '0;
      bo_q   <= DLY_INA;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      dly_q  <= dly_d;
      bo_q   <= bo_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
endmodule

module multisim_pull_arbiter #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int DELAY_ACTIVE   = 0,
  parameter int DELAY_INACTIVE = 3,
  parameter int DELAY_MAX      = 48,
  parameter int CHAN_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int DLY_W          = $clog2(DELAY_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHANNELS-1:0]          enable,
  output logic [NUM_CHANNELS-1:0]          data_vld,
  input  logic [NUM_CHANNELS-1:0]          data_rdy,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
  output logic                             pull_req_vld,
  input  logic                             pull_req_rdy,
  output logic [CHAN_W-1:0]                pull_req_chan,
  input  logic                             pull_rsp_vld,
  input  logic                             pull_rsp_hit,
  input  logic [DATA_WIDTH-1:0]            pull_rsp_data,
  output logic                             busy
);
  localparam logic [CHAN_W-1:0] RR_RST = CHAN_W'(NUM_CHANNELS - 1);

  logic                                   req_q, out_q;
  logic [CHAN_W-1:0]                      chan_q, rr_q;
  logic                                   busy_w, rsp_acc;
  logic [NUM_CHANNELS-1:0]                elig, gnt;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data;
  logic                                   gnt_any;
  logic [CHAN_W-1:0]                      gnt_idx;
  int                                     idx;

  assign busy_w        = req_q | out_q;
  assign rsp_acc       = out_q & pull_rsp_vld;
  assign busy          = busy_w;
  assign pull_req_vld  = req_q;
  assign pull_req_chan = chan_q;

  // round-robin: first eligible index strictly after rr_q, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (int'(rr_q) + k) % NUM_CHANNELS;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CHAN_W'(idx);
      end
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign gnt[i] = gnt_any && (gnt_idx == CHAN_W'(i));
    assign data[i*DATA_WIDTH +: DATA_WIDTH] = ch_data[i];

    multisim_pull_chan #(
      .DATA_WIDTH    (DATA_WIDTH),
      .DELAY_ACTIVE  (DELAY_ACTIVE),
      .DELAY_INACTIVE(DELAY_INACTIVE),
      .DELAY_MAX     (DELAY_MAX),
      .DLY_W         (DLY_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (enable[i]),
      .rdy_i     (data_rdy[i]),
      .busy_i    (busy_w),
      .gnt_i     (gnt[i]),
      .rsp_i     (rsp_acc && (chan_q == CHAN_W'(i))),
      .hit_i     (pull_rsp_hit),
      .rsp_data_i(pull_rsp_data),
      .vld_o     (data_vld[i]),
      .data_o    (ch_data[i]),
      .elig_o    (elig[i])
    );
  end

  // grants only happen while idle, so the three branches are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      out_q  <= 1'b0;
      chan_q <= '0;
      rr_q   <= RR_RST;
    end else if (gnt_any) begin
      req_q  <= 1'b1;
      chan_q <= gnt_idx;
      rr_q   <= gnt_idx;
    end else if (req_q && pull_req_rdy) begin
      req_q <= 1'b0;
      out_q <= 1'b1;
    end else if (rsp_acc) begin
      out_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// Directed bench for multisim_pull_arbiter: hit streaming, backoff growth,
// round-robin order, backpressure, request stall and mid-flight reset.

module tb_multisim_pull_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    enable = '0;
  logic [N-1:0]    data_vld;
  logic [N-1:0]    data_rdy = '0;
  logic [N*DW-1:0] data;
  logic            pull_req_vld;
  logic            pull_req_rdy = 1'b1;
  logic [1:0]      pull_req_chan;
  logic            pull_rsp_vld = 1'b0;
  logic            pull_rsp_hit = 1'b0;
  logic [DW-1:0]   pull_rsp_data = '0;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multisim_pull_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .data_vld     (data_vld),
    .data_rdy     (data_rdy),
    .data         (data),
    .pull_req_vld (pull_req_vld),
    .pull_req_rdy (pull_req_rdy),
    .pull_req_chan(pull_req_chan),
    .pull_rsp_vld (pull_rsp_vld),
    .pull_rsp_hit (pull_rsp_hit),
    .pull_rsp_data(pull_rsp_data),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = '0;
    pull_rsp_vld = 1'b0;
    step();
    step();
    chk("rst_vld", data_vld, 0);
    chk("rst_data", data, 0);
    chk("rst_req", pull_req_vld, 0);
    chk("rst_chan", pull_req_chan, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
  endtask

  // Waits for a request (cycles counted), accepts it, answers one cycle later.
  task automatic xact(input string tag, input logic hit, input logic [7:0] d,
                      input int exp_chan, input int exp_wait);
    int n;
    n = 0;
    while (pull_req_vld !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_chan"}, pull_req_chan, exp_chan);
    step();
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = hit;
    pull_rsp_data = d;
    step();
    pull_rsp_vld  = 1'b0;
    pull_rsp_hit  = 1'b0;
    pull_rsp_data = '0;
    chk({tag, "_vld"}, data_vld[exp_chan], hit);
    if (hit) chk({tag, "_data"}, data[exp_chan*DW +: DW], d);
  endtask

  int bo_wait [9] = '{1, 4, 7, 13, 25, 49, 49, 1, 4};

  initial begin
    do_reset();

    // single channel, always hit: one beat every 3 cycles, data in order
    enable   = 4'b0001;
    data_rdy = 4'b1111;
    xact("hit0", 1'b1, 8'h11, 0, 1);
    xact("hit1", 1'b1, 8'h22, 0, 1);
    xact("hit2", 1'b1, 8'h33, 0, 1);
    xact("hit3", 1'b1, 8'h44, 0, 1);
    enable = '0;
    step();
    chk("drain_vld", data_vld[0], 0);

    // backoff: delays 3,6,12,24,48,48, then a hit, then miss loads 3 again
    enable = 4'b0001;
    for (int i = 0; i < 9; i++)
      xact($sformatf("bo%0d", i), (i == 6), 8'hB0, 0, bo_wait[i]);
    enable = '0;

    // round robin over all channels, then over enable=1010
    do_reset();
    enable = 4'b1111;
    for (int i = 0; i < 8; i++)
      xact($sformatf("rr%0d", i), 1'b1, 8'(8'h30 + i), i % 4, 1);
    enable = 4'b1010;
    xact("rrm0", 1'b1, 8'h41, 1, 1);
    xact("rrm1", 1'b1, 8'h43, 3, 1);
    xact("rrm2", 1'b1, 8'h51, 1, 1);
    xact("rrm3", 1'b1, 8'h53, 3, 1);

    // backpressure on channel 2 while others keep being served
    do_reset();
    data_rdy = 4'b1011;
    enable   = 4'b0100;
    xact("bp_fill", 1'b1, 8'hA5, 2, 1);
    enable = 4'b1111;
    xact("bp_c3", 1'b1, 8'hC3, 3, 1);
    chk("bp_hold_v0", data_vld[2], 1);
    chk("bp_hold_d0", data[2*DW +: DW], 8'hA5);
    xact("bp_c0", 1'b1, 8'hC0, 0, 1);
    chk("bp_hold_v1", data_vld[2], 1);
    chk("bp_hold_d1", data[2*DW +: DW], 8'hA5);
    xact("bp_c1", 1'b1, 8'hC1, 1, 1);
    enable = 4'b0100;
    step();
    chk("bp_noreq", pull_req_vld, 0);
    chk("bp_hold_v2", data_vld[2], 1);
    chk("bp_hold_d2", data[2*DW +: DW], 8'hA5);
    data_rdy = 4'b1111;
    step();
    chk("bp_rel_req", pull_req_vld, 1);
    chk("bp_rel_chan", pull_req_chan, 2);
    chk("bp_rel_vld", data_vld[2], 0);
    xact("bp_next", 1'b1, 8'h5A, 2, 0);

    // request stall with enable dropping while REQ is held
    do_reset();
    pull_req_rdy = 1'b0;
    enable       = 4'b0010;
    step();
    chk("st_req", pull_req_vld, 1);
    chk("st_chan", pull_req_chan, 1);
    enable = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("st_hold_req%0d", i), pull_req_vld, 1);
      chk($sformatf("st_hold_chan%0d", i), pull_req_chan, 1);
    end
    pull_req_rdy = 1'b1;
    step();
    chk("st_acc_req", pull_req_vld, 0);
    chk("st_acc_busy", busy, 1);
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'h77;
    step();
    pull_rsp_vld = 1'b0;
    chk("st_vld", data_vld[1], 1);
    chk("st_data", data[1*DW +: DW], 8'h77);

    // reset while OUT with channel 1 pending
    enable = 4'b0010;
    step();
    chk("mr_req", pull_req_vld, 1);
    chk("mr_beat", data_vld[1], 0);
    step();
    chk("mr_out_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_vld", data_vld, 0);
    chk("mr_data", data, 0);
    chk("mr_req0", pull_req_vld, 0);
    chk("mr_busy", busy, 0);
    enable = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'h99;
    step();
    pull_rsp_vld = 1'b0;
    step();
    chk("mr_stray_vld", data_vld[1], 0);
    chk("mr_stray_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
